fp_classify_unit: RTL and testbench

Pipelined, multi-lane IEEE 754 classifier for the FPU execute path. Classifies LANES operands of a parametrised binary format (FP32 default; FP16/BF16 by parameter) per transaction. Produces a RISC-V FCLASS-style 10-bit one-hot mask per lane, with valid/ready flow control and a two-stage pipeline. Keeps a sticky invalid (NV) flag and a saturating sNaN event counter for the FP CSR logic.

---
 rtl/fp_classify_unit_pkg.sv | 47 ++++
 rtl/fp_classify_unit_lane_decode.sv | 30 +++
 rtl/fp_classify_unit.sv | 147 ++++++++++++++
 tb/tb_fp_classify_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_classify_unit_pkg.sv
// FCLASS mask layout and the per-lane one-hot encoder.
// Pure combinational helpers. No state and no flow control.
// Backpressure does not apply here. The importing module sequences all use.
package fp_classify_unit_pkg;

    localparam int FCLASS_WIDTH   = 10;

    typedef logic [FCLASS_WIDTH-1:0] fclass_t;

    localparam int FCLASS_NEG_INF  = 0;
    localparam int FCLASS_NEG_NORM = 1;
    localparam int FCLASS_NEG_SUB  = 2;
    localparam int FCLASS_NEG_ZERO = 3;
    localparam int FCLASS_POS_ZERO = 4;
    localparam int FCLASS_POS_SUB  = 5;
    localparam int FCLASS_POS_NORM = 6;
    localparam int FCLASS_POS_INF  = 7;
    localparam int FCLASS_SNAN     = 8;
    localparam int FCLASS_QNAN     = 9;

    // The if-chain order below is the classification priority.
    // NaN classes deliberately ignore the sign bit.
    function automatic fclass_t fclass_encode(
        input logic sign,
        input logic exp_zero,
        input logic exp_ones,
        input logic mant_zero,
        input logic mant_msb
    );
        int idx;
        if (exp_zero && mant_zero) begin
            idx = sign ? FCLASS_NEG_ZERO : FCLASS_POS_ZERO;
        end else if (exp_zero) begin
            idx = sign ? FCLASS_NEG_SUB : FCLASS_POS_SUB;
        end else if (exp_ones && mant_zero) begin
            idx = sign ? FCLASS_NEG_INF : FCLASS_POS_INF;
        end else if (exp_ones && mant_msb) begin
            idx = FCLASS_QNAN;
        end else if (exp_ones) begin
            idx = FCLASS_SNAN;
        end else begin
            idx = sign ? FCLASS_NEG_NORM : FCLASS_POS_NORM;
        end
        return fclass_t'(1) << idx;
    endfunction

endpackage

// File: rtl/fp_classify_unit_lane_decode.sv
// Splits one IEEE 754 operand into the field predicates that the classifier needs.
// The block is purely combinational, so it adds no latency.
// It has no handshake. The parent pipeline registers the outputs.
module fp_lane_decode #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23
) (
    input  logic [EXP_WIDTH+MANT_WIDTH:0] op,
    output logic                          sign,
    output logic                          exp_zero,
    output logic                          exp_ones,
    output logic                          mant_zero,
    output logic                          mant_msb
);
    localparam int W = 1 + EXP_WIDTH + MANT_WIDTH;

    logic [EXP_WIDTH-1:0]  exp_f;
    logic [MANT_WIDTH-1:0] mant_f;

    assign exp_f     = op[W-2 -: EXP_WIDTH];
    assign mant_f    = op[MANT_WIDTH-1:0];

    assign sign      = op[W-1];
    assign exp_zero  = ~|exp_f;
    assign exp_ones  = &exp_f;
    assign mant_zero = ~|mant_f;
    // The quiet bit tells qNaN apart from sNaN.
    assign mant_msb  = mant_f[MANT_WIDTH-1];

endmodule

// File: rtl/fp_classify_unit.sv
// Multi-lane FCLASS classifier. It keeps a sticky NV flag and a saturating sNaN counter.
// The pipeline is 2 stages deep: input handshake to out_valid in 2 cycles, at 1 transaction per cycle.
// in_ready comes combinationally from out_ready. The block holds at most 2 transactions, and outputs stay stable while stalled.
module fp_classify_unit
    import fp_classify_unit_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int TAG_WIDTH  = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [LANES*(1+EXP_WIDTH+MANT_WIDTH)-1:0] in_data,
    input  logic [LANES-1:0]                     in_lane_mask,
    input  logic [TAG_WIDTH-1:0]                 in_tag,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [LANES*FCLASS_WIDTH-1:0]        out_class,
    output logic [LANES-1:0]                     out_lane_mask,
    output logic [TAG_WIDTH-1:0]                 out_tag,
    output logic                                 out_any_nan,
    output logic                                 flag_nv,
    input  logic                                 flag_clr,
    output logic [CNT_WIDTH-1:0]                 snan_count
);
    localparam int W     = 1 + EXP_WIDTH + MANT_WIDTH;
    localparam int KW    = $clog2(LANES + 1);
    localparam int SUM_W = ((CNT_WIDTH > KW) ? CNT_WIDTH : KW) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_WIDTH){1'b0}}, {CNT_WIDTH{1'b1}}};

    logic s1_valid;
    logic s2_valid;
    logic s1_en;
    logic s2_en;
    logic out_hs;

    logic [LANES-1:0] dec_sign, dec_exp_zero, dec_exp_ones, dec_mant_zero, dec_mant_msb;
    logic [LANES-1:0] s1_sign, s1_exp_zero, s1_exp_ones, s1_mant_zero, s1_mant_msb;
    logic [LANES-1:0] s1_lane_mask;
    logic [TAG_WIDTH-1:0] s1_tag;

    fclass_t                      lane_class [LANES];
    logic [LANES-1:0]             lane_nan;
    logic [LANES*FCLASS_WIDTH-1:0] s2_class_d;
    logic [LANES-1:0]             out_snan;
    logic [KW-1:0]                snan_k;
    logic [SUM_W-1:0]             cnt_sum;

    assign s2_en    = !s2_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;
    assign out_valid = s2_valid;
    assign out_hs   = s2_valid && out_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp_lane_decode #(
            .EXP_WIDTH (EXP_WIDTH),
            .MANT_WIDTH(MANT_WIDTH)
        ) u_decode (
            .op       (in_data[i*W +: W]),
            .sign     (dec_sign[i]),
            .exp_zero (dec_exp_zero[i]),
            .exp_ones (dec_exp_ones[i]),
            .mant_zero(dec_mant_zero[i]),
            .mant_msb (dec_mant_msb[i])
        );

        // Inactive lanes produce an all-zero mask. Any-NaN and the sNaN count inherit that for free.
        assign lane_class[i] = s1_lane_mask[i]
                             ? fclass_encode(s1_sign[i], s1_exp_zero[i], s1_exp_ones[i],
                                             s1_mant_zero[i], s1_mant_msb[i])
                             : '0;
        assign lane_nan[i]   = lane_class[i][FCLASS_SNAN] | lane_class[i][FCLASS_QNAN];
        assign s2_class_d[i*FCLASS_WIDTH +: FCLASS_WIDTH] = lane_class[i];
        assign out_snan[i]   = out_class[i*FCLASS_WIDTH + FCLASS_SNAN];
    end

    // Stage 1 holds the field predicates, lane mask and tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_sign      <= '0;
            s1_exp_zero  <= '0;
            s1_exp_ones  <= '0;
            s1_mant_zero <= '0;
            s1_mant_msb  <= '0;
            s1_lane_mask <= '0;
            s1_tag       <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign      <= dec_sign;
                s1_exp_zero  <= dec_exp_zero;
                s1_exp_ones  <= dec_exp_ones;
                s1_mant_zero <= dec_mant_zero;
                s1_mant_msb  <= dec_mant_msb;
                s1_lane_mask <= in_lane_mask;
                s1_tag       <= in_tag;
            end
        end
    end

    // Stage 2 loads only from a valid stage 1, so the outputs never change under a stall or a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid      <= 1'b0;
            out_class     <= '0;
            out_any_nan   <= 1'b0;
            out_lane_mask <= '0;
            out_tag       <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_class     <= s2_class_d;
                out_any_nan   <= |lane_nan;
                out_lane_mask <= s1_lane_mask;
                out_tag       <= s1_tag;
            end
        end
    end

    assign snan_k  = KW'($countones(out_snan));
    assign cnt_sum = SUM_W'(snan_count) + SUM_W'(snan_k);

    // If a new sNaN arrives in the same cycle as a clear, the set takes priority so no event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_nv    <= 1'b0;
            snan_count <= '0;
        end else begin
            if (out_hs && (snan_k != '0)) begin
                flag_nv <= 1'b1;
            end else if (flag_clr) begin
                flag_nv <= 1'b0;
            end
            if (out_hs) begin
                snan_count <= (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_WIDTH-1:0]
                                                  : cnt_sum[CNT_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_fp_classify_unit.sv
// Bench for fp_classify_unit: an FP32 instance with default parameters and an FP16 instance with a 2-bit counter.
module tb_fp_classify_unit;
    localparam int LANES = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_any_nan, a_flag_nv, a_flag_clr;
    logic [127:0] a_in_data;
    logic [3:0]  a_in_lane_mask, a_out_lane_mask;
    logic [5:0]  a_in_tag, a_out_tag;
    logic [39:0] a_out_class;
    logic [15:0] a_snan_count;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_any_nan, b_flag_nv, b_flag_clr;
    logic [63:0] b_in_data;
    logic [3:0]  b_in_lane_mask, b_out_lane_mask;
    logic [5:0]  b_in_tag, b_out_tag;
    logic [39:0] b_out_class;
    logic [1:0]  b_snan_count;

    fp_classify_unit u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_lane_mask(a_in_lane_mask), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_class(a_out_class),
        .out_lane_mask(a_out_lane_mask), .out_tag(a_out_tag), .out_any_nan(a_out_any_nan),
        .flag_nv(a_flag_nv), .flag_clr(a_flag_clr), .snan_count(a_snan_count)
    );

    fp_classify_unit #(.LANES(4), .EXP_WIDTH(5), .MANT_WIDTH(10), .TAG_WIDTH(6), .CNT_WIDTH(2)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_lane_mask(b_in_lane_mask), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_class(b_out_class),
        .out_lane_mask(b_out_lane_mask), .out_tag(b_out_tag), .out_any_nan(b_out_any_nan),
        .flag_nv(b_flag_nv), .flag_clr(b_flag_clr), .snan_count(b_snan_count)
    );

    typedef struct {
        logic [127:0] data;
        logic [3:0]   mask;
        logic [5:0]   tag;
        logic [39:0]  cls;
        logic         nan;
        logic         flag;
        logic [15:0]  cnt;
    } vec_t;

    typedef struct {
        logic [39:0] cls;
        logic        nan;
        logic [3:0]  mask;
        logic [5:0]  tag;
    } exp_t;

    vec_t vt [5];
    logic [1:0] b_cnt_exp [4];
    int   m_cnt;
    logic m_flag;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference classifier: works on the numeric field values, with no knowledge of pipeline structure.
    function automatic logic [9:0] ref_class(input logic [31:0] v, input int ew, input int mw);
        int unsigned x, e, m, s, emax;
        x    = v;
        emax = (1 << ew) - 1;
        e    = (x >> mw) & emax;
        m    = x & ((1 << mw) - 1);
        s    = (x >> (ew + mw)) & 1;
        if (e == 0 && m == 0) return (s != 0) ? 10'h008 : 10'h010;
        if (e == 0)           return (s != 0) ? 10'h004 : 10'h020;
        if (e == emax && m == 0) return (s != 0) ? 10'h001 : 10'h080;
        if (e == emax)        return (m >= (1 << (mw - 1))) ? 10'h200 : 10'h100;
        return (s != 0) ? 10'h002 : 10'h040;
    endfunction

    function automatic logic [31:0] rand_fp32();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 4))
            0: v[30:23] = 8'h00;
            1: v[30:23] = 8'hFF;
            2: begin v[30:23] = 8'hFF; v[22:0] = '0; end
            3: v[30:0] = '0;
            default: ;
        endcase
        return v;
    endfunction

    task automatic a_gen(input logic [5:0] tag, input bit rnd, output exp_t e);
        logic [31:0] v;
        e.cls  = '0;
        e.nan  = 1'b0;
        e.tag  = tag;
        e.mask = rnd ? 4'($urandom) : 4'hF;
        for (int l = 0; l < LANES; l++) begin
            v = rand_fp32();
            a_in_data[l*32 +: 32] = v;
            if (e.mask[l]) e.cls[l*10 +: 10] = ref_class(v, 8, 23);
            e.nan = e.nan | e.cls[l*10 + 8] | e.cls[l*10 + 9];
        end
        a_in_lane_mask = e.mask;
        a_in_tag       = tag;
    endtask

    task automatic a_send(input logic [127:0] d, input logic [3:0] m, input logic [5:0] t, input string nm);
        a_in_data = d; a_in_lane_mask = m; a_in_tag = t; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(negedge clk); chk({nm, "_in_ready"}, a_in_ready, 1);
        @(posedge clk); #1 a_in_valid = 1'b0;
        @(negedge clk); chk({nm, "_valid_after_1"}, a_out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk); chk({nm, "_valid_after_2"}, a_out_valid, 1);
    endtask

    task automatic b_send(input logic [63:0] d, input logic [3:0] m, input logic [5:0] t, input string nm);
        b_in_data = d; b_in_lane_mask = m; b_in_tag = t; b_in_valid = 1'b1; b_out_ready = 1'b1;
        @(negedge clk); chk({nm, "_in_ready"}, b_in_ready, 1);
        @(posedge clk); #1 b_in_valid = 1'b0;
        @(negedge clk); chk({nm, "_valid_after_1"}, b_out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk); chk({nm, "_valid_after_2"}, b_out_valid, 1);
    endtask

    // Streaming scoreboard. rnd=0 runs a scripted 3-cycle stall; rnd=1 randomizes ready, valid, masks and clears.
    task automatic a_stream(input int n_txn, input bit rnd, input int budget);
        exp_t q[$];
        exp_t pend, e;
        int sent = 0, got = 0, cyc = 0, occ = 0, k;
        bit in_hs, out_hs, stall_prev = 0, saw_block = 0;
        logic [51:0] prev_out;
        a_gen(6'(sent), rnd, pend);
        a_in_valid = !rnd || ($urandom_range(0, 3) != 0);
        while (got < n_txn && cyc < budget) begin
            a_out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 4 && cyc < 7);
            a_flag_clr  = rnd && ($urandom_range(0, 15) == 0);
            @(negedge clk);
            chk("stream_flag_nv", a_flag_nv, m_flag);
            chk("stream_snan_count", a_snan_count, 16'(m_cnt));
            chk("stream_in_ready", a_in_ready, a_out_ready || (occ < 2));
            if (!a_in_ready) saw_block = 1;
            if (stall_prev)
                chk("stream_stall_hold", {a_out_valid, a_out_class, a_out_tag, a_out_lane_mask, a_out_any_nan}, prev_out);
            out_hs = a_out_valid && a_out_ready;
            in_hs  = a_in_valid && a_in_ready;
            k = 0;
            if (out_hs) begin
                if (q.size() == 0) begin
                    chk("stream_unexpected_output", 64'(q.size()), 1);
                end else begin
                    e = q.pop_front();
                    chk("stream_class", a_out_class, e.cls);
                    chk("stream_any_nan", a_out_any_nan, e.nan);
                    chk("stream_lane_mask", a_out_lane_mask, e.mask);
                    chk("stream_tag", a_out_tag, e.tag);
                    for (int l = 0; l < LANES; l++) k += int'(e.cls[l*10 + 8]);
                end
                got++;
                occ--;
            end
            if (out_hs && k > 0) m_flag = 1'b1;
            else if (a_flag_clr) m_flag = 1'b0;
            m_cnt = (m_cnt + k > 65535) ? 65535 : m_cnt + k;
            if (in_hs) begin
                q.push_back(pend);
                sent++;
                occ++;
            end
            stall_prev = a_out_valid && !a_out_ready;
            prev_out   = {a_out_valid, a_out_class, a_out_tag, a_out_lane_mask, a_out_any_nan};
            @(posedge clk); #1;
            if (in_hs || !a_in_valid) begin
                if (sent < n_txn && (!rnd || $urandom_range(0, 3) != 0)) begin
                    a_gen(6'(sent), rnd, pend);
                    a_in_valid = 1'b1;
                end else begin
                    a_in_valid = 1'b0;
                end
            end
            cyc++;
        end
        chk("stream_delivered", 64'(got), 64'(n_txn));
        if (!rnd) chk("stream_in_ready_dropped", 64'(saw_block), 1);
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_flag_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{{32'h80000000, 32'h00000001, 32'hFF800000, 32'h7F800001}, 4'hF, 6'h01,
                  {10'h008, 10'h020, 10'h001, 10'h100}, 1'b1, 1'b1, 16'd1};
        vt[1] = '{{32'h00000000, 32'hBF800000, 32'h3F800000, 32'h7FC00000}, 4'hF, 6'h02,
                  {10'h010, 10'h002, 10'h040, 10'h200}, 1'b1, 1'b1, 16'd1};
        vt[2] = '{{4{32'h7F800001}}, 4'h0, 6'h03, 40'h0, 1'b0, 1'b1, 16'd1};
        vt[3] = '{{32'hFFA00000, 32'h807FFFFF, 32'hFFC00001, 32'h7F800000}, 4'b0101, 6'h04,
                  {10'h000, 10'h004, 10'h000, 10'h080}, 1'b0, 1'b1, 16'd1};
        vt[4] = '{{32'h7FFFFFFF, 32'h7F7FFFFF, 32'hFFBFFFFF, 32'h00000000}, 4'b1010, 6'h05,
                  {10'h200, 10'h000, 10'h100, 10'h000}, 1'b1, 1'b1, 16'd2};
        b_cnt_exp = '{2'd2, 2'd3, 2'd3, 2'd3};

        rst = 1'b1;
        a_in_valid = 0; a_in_data = '0; a_in_lane_mask = '0; a_in_tag = '0; a_out_ready = 0; a_flag_clr = 0;
        b_in_valid = 0; b_in_data = '0; b_in_lane_mask = '0; b_in_tag = '0; b_out_ready = 0; b_flag_clr = 0;
        #1;
        chk("reset_out_valid", a_out_valid, 0);
        chk("reset_out_class", a_out_class, 0);
        chk("reset_flag_nv", a_flag_nv, 0);
        chk("reset_snan_count", a_snan_count, 0);
        chk("reset_tag_mask_nan", {a_out_tag, a_out_lane_mask, a_out_any_nan}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_reset_in_ready", a_in_ready, 1);
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            a_send(vt[i].data, vt[i].mask, vt[i].tag, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_class", i), a_out_class, vt[i].cls);
            chk($sformatf("vec%0d_any_nan", i), a_out_any_nan, vt[i].nan);
            chk($sformatf("vec%0d_tag_mask", i), {a_out_tag, a_out_lane_mask}, {vt[i].tag, vt[i].mask});
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("vec%0d_flag_nv", i), a_flag_nv, vt[i].flag);
            chk($sformatf("vec%0d_snan_count", i), a_snan_count, vt[i].cnt);
            chk($sformatf("vec%0d_drained", i), a_out_valid, 0);
            @(posedge clk); #1;
        end

        // Sticky NV: clear alone, then a clear that coincides with an sNaN handshake, then clear alone again.
        a_flag_clr = 1'b1;
        @(posedge clk); #1 a_flag_clr = 1'b0;
        @(negedge clk); chk("nv_clear_alone", a_flag_nv, 0);
        @(posedge clk); #1;
        a_send({96'h0, 32'h7F800001}, 4'b0001, 6'h06, "nv_txn");
        a_flag_clr = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("nv_set_beats_clear", a_flag_nv, 1);
        chk("nv_count", a_snan_count, 3);
        @(posedge clk); #1 a_flag_clr = 1'b0;
        @(negedge clk); chk("nv_clear_next", a_flag_nv, 0);
        @(posedge clk); #1;

        m_flag = 1'b0;
        m_cnt  = 3;
        a_stream(8, 1'b0, 100);
        a_stream(300, 1'b1, 5000);

        b_send({16'hFC01, 16'h0001, 16'hFE00, 16'h7C00}, 4'b0111, 6'h11, "fp16");
        chk("fp16_class", b_out_class, {10'h000, 10'h020, 10'h200, 10'h080});
        chk("fp16_any_nan", b_out_any_nan, 1);
        @(posedge clk); #1;
        @(negedge clk); chk("fp16_count", {b_flag_nv, b_snan_count}, 0);
        @(posedge clk); #1;

        for (int j = 0; j < 4; j++) begin
            b_send({16'h3C00, 16'h7C01, 16'h7C01, 16'h7D00}, 4'b1011, 6'(j + 32), $sformatf("sat%0d", j));
            chk($sformatf("sat%0d_class", j), b_out_class, {10'h040, 10'h000, 10'h100, 10'h100});
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("sat%0d_count", j), b_snan_count, b_cnt_exp[j]);
            chk($sformatf("sat%0d_flag", j), b_flag_nv, 1);
            @(posedge clk); #1;
        end

        // Reset mid-flight: both stages are occupied while the consumer is stalled.
        b_out_ready = 1'b0;
        b_in_data = {4{16'h7C01}}; b_in_lane_mask = 4'hF; b_in_tag = 6'h2A; b_in_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        b_in_valid = 1'b0;
        @(negedge clk); chk("midflight_out_valid_before", b_out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("midflight_out_valid", b_out_valid, 0);
        chk("midflight_count_flag", {b_flag_nv, b_snan_count}, 0);
        chk("midflight_outputs", {b_out_class, b_out_tag, b_out_lane_mask, b_out_any_nan}, 0);
        @(negedge clk); rst = 1'b0;
        b_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); chk("midflight_in_ready", b_in_ready, 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); chk($sformatf("midflight_discard%0d", c), b_out_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
